picomips_mc_core: RTL and testbench
===================================

# picomips_mc_core

Parametrised multi-cycle successor to the single-cycle picoMIPS datapath: a SUBLEQ/MULTI core with configurable data width, register count and program-counter width, plus HALT, run gating, a retired-instruction counter and switch/LED mapping through register 0. It fetches from an external synchronous program memory, executes one instruction per three-cycle FSM pass, and replaces the cycle generator, PC, register file and result multiplexer of the previous generation with a single block.

## Interface
- `DATA_WIDTH`, 8: register, switch and LED width; signed two's complement.
- `NUM_REGS`, 8: register count, ≥2. `RA_W = $clog2(NUM_REGS)`.
- `PC_WIDTH`, 8: PC/branch field width; must be ≥ `DATA_WIDTH`.
- `CNT_WIDTH`, 16: retired-instruction counter width.
- Derived: `INSTR_WIDTH = 2 + 2*RA_W + PC_WIDTH`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: level enable; fetch of a new instruction only while high.
- `imem_addr` out `PC_WIDTH`: program address (equals PC).
- `imem_data` in `INSTR_WIDTH`: program word, valid one cycle after address (synchronous ROM).
- `sw` in `DATA_WIDTH`: switches, read as register 0.
- `led` out `DATA_WIDTH`: LED register, written via register 0.
- `halted` out 1: high once HALT retires.
- `instr_count` out `CNT_WIDTH`: retired instructions, saturating.

## Operation
- Instruction fields, MSB first: opcode[1:0], r1 (`RA_W`), r2 (`RA_W`), field (`PC_WIDTH`). Immediate = field[`DATA_WIDTH`-1:0], signed.
- Opcodes: 00 SUBLEQ, 01 MULTI, 10 NOP, 11 HALT.
- SUBLEQ: r2 ← r2 − r1 (wrap mod 2^`DATA_WIDTH`); if result ≤ 0 signed, PC ← field, else PC ← PC+1.
- MULTI: signed product r1 × imm (2·`DATA_WIDTH` bits); r2 ← product[2W−2 : W−1] (Q1.(W−1) fractional); PC ← PC+1. Never branches.
- NOP: PC ← PC+1, no write. HALT: PC unchanged, `halted` ← 1, FSM → HALT.
- Register 0: reads return `sw`; writes load `led`. Registers 1..`NUM_REGS`−1 are storage. r1 = r2 permitted (SUBLEQ of a register with itself gives 0, branch taken).
- PC+1 wraps from 2^`PC_WIDTH`−1 to 0.
- `instr_count` increments at end of every EXEC (HALT included); holds at all-ones.
- FSM: FETCH → DECODE when `run`=1, else stay FETCH. DECODE → EXEC (latch `imem_data` into instruction register). EXEC → FETCH, or → HALT for opcode 11. HALT is terminal; only `reset` leaves it.
- `run` dropping in DECODE or EXEC does not abort; the instruction completes and the FSM waits in FETCH.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state FETCH, PC 0, `imem_addr` 0, all registers 0, `led` 0, `halted` 0, `instr_count` 0.
- Per instruction: 3 cycles when `run` held high (FETCH, DECODE, EXEC).
- FETCH: `imem_addr` = PC. DECODE: `imem_data` sampled at the edge ending DECODE.
- EXEC: operands read combinationally from instruction register and register file / `sw`; register, `led`, PC, `halted`, `instr_count` all update on the edge ending EXEC.
- `sw` sampled during EXEC only.
- Reset mid-instruction: instruction discarded, no partial writes survive.

## Configuration
- `PICOMIPS_SAT_EN` defined: MULTI with r1 and imm both most-negative (−1 × −1) yields max positive (0x7F for W=8) instead of wrapping.
- Undefined: plain truncation; −1 × −1 yields most-negative (0x80 for W=8).

## Test plan
- Reset then `run`=1, program at 0: SUBLEQ r1=r2=3 (preloaded via earlier SUBLEQs), field 0x20 -> r2=0, PC=0x20 after EXEC, `instr_count`=retired count.
- SUBLEQ r2=5, r1=3 -> r2=2, PC+1; SUBLEQ r2=0x80, r1=1 -> r2=0x7F, not taken.
- MULTI r1=0x40, imm=0x40 -> 0x20; MULTI r1=0x80, imm=0x80 -> 0x7F with `PICOMIPS_SAT_EN`, 0x80 without.
- `sw`=0x05, SUBLEQ r1=reg3 (=2), r2=reg0 -> `led`=0x03 one edge after EXEC, not taken.
- `run` low in DECODE -> instruction completes, FSM parks in FETCH, `imem_addr` stable; HALT -> `halted`=1, PC frozen, `run` ignored until reset.
- Reset asserted during EXEC -> all outputs 0 next cycle; NOP at 0xFF -> PC wraps to 0x00.

Source files
------------

// File: rtl/picomips_mc_core.sv
// picomips_mc_core: multi-cycle SUBLEQ/MULTI core, FETCH/DECODE/EXEC per instruction.
// Define PICOMIPS_SAT_EN to saturate MULTI of two most-negative operands.
module picomips_mc_core #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS = 8,
  parameter int PC_WIDTH = 8,
  parameter int CNT_WIDTH = 16,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int INSTR_WIDTH = 2 + 2 * RA_W + PC_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic [DATA_WIDTH-1:0]  sw,
  output logic [DATA_WIDTH-1:0]  led,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   instr_count
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    OP_SUBLEQ,
    OP_MULTI,
    OP_NOP,
    OP_HALT
  } op_t;

  state_t state, state_nx;

  logic [INSTR_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]    pc;
  logic [W-1:0]           regs [NUM_REGS];

  op_t                 op;
  logic [RA_W-1:0]     r1, r2;
  logic [PC_WIDTH-1:0] field;
  logic [W-1:0]        imm;
  logic [W-1:0]        opa, opb;
  logic [W-1:0]        diff;
  logic                leq;
  logic [2*W-1:0]      prod;
  logic [W-1:0]        mres;
  logic                wr_en;
  logic [W-1:0]        wr_val;
  logic [PC_WIDTH-1:0] pc_nx;
  logic                unused_prod;

  assign op    = op_t'(ir[INSTR_WIDTH-1 -: 2]);
  assign r1    = ir[INSTR_WIDTH-3 -: RA_W];
  assign r2    = ir[INSTR_WIDTH-3-RA_W -: RA_W];
  assign field = ir[PC_WIDTH-1:0];
  assign imm   = field[W-1:0];

  assign opa = (r1 == '0) ? sw : regs[r1];
  assign opb = (r2 == '0) ? sw : regs[r2];

  assign diff = opb - opa;
  assign leq  = diff[W-1] || (diff == '0);

  assign prod = {{W{opa[W-1]}}, opa} * {{W{imm[W-1]}}, imm};
  assign unused_prod = ^{prod[2*W-1], prod[W-2:0]};

  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  // Q1.(W-1) product extraction, optionally clamping the -1 x -1 corner
  always_comb begin
    mres = prod[2*W-2:W-1];
`ifdef PICOMIPS_SAT_EN
    if (opa == {1'b1, {(W-1){1'b0}}} && imm == {1'b1, {(W-1){1'b0}}})
      mres = {1'b0, {(W-1){1'b1}}};
`endif
  end

  // Opcode decode: write-back value and next PC
  always_comb begin
    wr_en  = 1'b0;
    wr_val = '0;
    pc_nx  = pc + 1'b1;
    unique case (op)
      OP_SUBLEQ: begin
        wr_en  = 1'b1;
        wr_val = diff;
        if (leq) pc_nx = field;
      end
      OP_MULTI: begin
        wr_en  = 1'b1;
        wr_val = mres;
      end
      OP_NOP:  pc_nx = pc + 1'b1;
      OP_HALT: pc_nx = pc;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH:  if (run) state_nx = S_DECODE;
      S_DECODE: state_nx = S_EXEC;
      S_EXEC:   state_nx = (op == OP_HALT) ? S_HALT : S_FETCH;
      S_HALT:   state_nx = S_HALT;
    endcase
  end

  // Datapath: instruction latch, register file, LED, PC and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir          <= '0;
      pc          <= '0;
      led         <= '0;
      instr_count <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (state == S_DECODE) ir <= imem_data;
      if (state == S_EXEC) begin
        pc <= pc_nx;
        if (instr_count != '1) instr_count <= instr_count + 1'b1;
        if (wr_en) begin
          if (r2 == '0) led      <= wr_val;
          else          regs[r2] <= wr_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_picomips_mc_core.sv
// tb_picomips_mc_core: directed and random programs against an
// instruction-level reference model of the core.
module tb_picomips_mc_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        halted;
  logic [15:0] instr_count;

  logic [15:0] prog [256];

  int checks = 0;
  int errors = 0;

  int mregs [8];
  int mled, mpc, mcnt, mhalt;

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= prog[imem_addr];

  picomips_mc_core dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .sw(sw),
    .led(led),
    .halted(halted),
    .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input int op, input int r1,
                                      input int r2, input int f);
    return {op[1:0], r1[2:0], r2[2:0], f[7:0]};
  endfunction

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int rd(input int r);
    return (r == 0) ? int'(sw) : mregs[r];
  endfunction

  task automatic wr(input int r, input int v);
    if (r == 0) mled = v;
    else mregs[r] = v;
  endtask

  task automatic mreset();
    foreach (mregs[i]) mregs[i] = 0;
    mled = 0; mpc = 0; mcnt = 0; mhalt = 0;
  endtask

  // One whole instruction at the architectural level
  task automatic model_step();
    logic [15:0] ins;
    int op, r1, r2, f, a, b, d, p, q;
    ins = prog[mpc];
    op = int'(ins[15:14]);
    r1 = int'(ins[13:11]);
    r2 = int'(ins[10:8]);
    f  = int'(ins[7:0]);
    a = rd(r1);
    b = rd(r2);
    case (op)
      0: begin
        d = (b - a) & 255;
        wr(r2, d);
        mpc = (sx(d) <= 0) ? f : (mpc + 1) % 256;
      end
      1: begin
        p = sx(a) * sx(f);
        q = p >>> 7;
`ifdef PICOMIPS_SAT_EN
        if (q == 128) q = 127;
`endif
        wr(r2, q & 255);
        mpc = (mpc + 1) % 256;
      end
      2: mpc = (mpc + 1) % 256;
      default: mhalt = 1;
    endcase
    if (mcnt < 65535) mcnt++;
  endtask

  task automatic cmp_all();
    check("pc", imem_addr, mpc);
    check("led", led, mled);
    check("cnt", instr_count, mcnt);
    check("halt", halted, mhalt);
  endtask

  task automatic step(input logic [7:0] s);
    sw = s;
    model_step();
    repeat (3) @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic step_drop(input logic [7:0] s);
    sw = s;
    model_step();
    @(posedge clk);
    #1 run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    repeat (5) @(posedge clk);
    #1;
    cmp_all();
    run = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    run   = 1'b1;
    sw    = 8'h00;
    for (int i = 0; i < 256; i++) prog[i] = enc(2, 0, 0, 0);
    prog[8'h00] = enc(0, 0, 3, 8'h10);
    prog[8'h01] = enc(0, 0, 2, 8'h10);
    prog[8'h02] = enc(0, 3, 3, 8'h20);
    prog[8'h20] = enc(0, 0, 4, 8'h50);
    prog[8'h21] = enc(0, 4, 2, 8'h50);
    prog[8'h22] = enc(0, 2, 0, 8'h50);
    prog[8'h23] = enc(0, 0, 5, 8'h24);
    prog[8'h24] = enc(0, 0, 6, 8'h50);
    prog[8'h25] = enc(0, 6, 5, 8'h60);
    prog[8'h26] = enc(0, 5, 0, 8'h27);
    prog[8'h27] = enc(0, 0, 1, 8'h50);
    prog[8'h28] = enc(1, 1, 0, 8'h40);
    prog[8'h29] = enc(1, 0, 0, 8'h80);
    prog[8'h2A] = enc(0, 3, 3, 8'hFF);
    prog[8'hFF] = enc(2, 0, 0, 0);
    mreset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", imem_addr, 0);
    check("rst_led", led, 0);
    check("rst_halt", halted, 0);
    check("rst_cnt", instr_count, 0);
    reset = 1'b1;

    step(8'hFD);
    step(8'hFB);
    step(8'h00);
    check("subleq_self_pc", imem_addr, 8'h20);
    step(8'hFD);
    step(8'h00);
    check("subleq_nt_pc", imem_addr, 8'h22);
    step(8'h05);
    check("led_sw", led, 8'h03);
    step(8'h80);
    step(8'hFF);
    step(8'h00);
    step(8'h00);
    check("subleq_wrap", led, 8'h81);
    step(8'hC0);
    step(8'h00);
    check("multi_q", led, 8'h20);
    step(8'h80);
`ifdef PICOMIPS_SAT_EN
    check("multi_min", led, 8'h7F);
`else
    check("multi_min", led, 8'h80);
`endif
    step(8'h00);
    check("branch_ff", imem_addr, 8'hFF);
    step(8'h00);
    check("pc_wrap", imem_addr, 8'h00);
    step_drop(8'hFD);

    sw = 8'h33;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("rst_exec_addr", imem_addr, 0);
    check("rst_exec_led", led, 0);
    check("rst_exec_cnt", instr_count, 0);
    @(posedge clk);
    #1;
    check("rst_hold_led", led, 0);
    check("rst_hold_halt", halted, 0);
    reset = 1'b1;
    mreset();

    for (int i = 0; i < 256; i++)
      prog[i] = enc($urandom_range(0, 2), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 255));
    for (int n = 0; n < 80; n++) step(8'($urandom_range(0, 255)));

    prog[mpc] = enc(3, 0, 0, 0);
    step(8'($urandom_range(0, 255)));
    check("halted", halted, 1);
    for (int n = 0; n < 12; n++) begin
      run = n[0];
      @(posedge clk);
      #1;
    end
    run = 1'b1;
    cmp_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
